alu_rr_scheduler: RTL and testbench

- Shares one combinational 32-bit ALU between NUM_REQ requesters using round-robin arbitration.
- Each requester hands over one operation (A, B, ALUControl) through a valid/ready handshake. The block drives the ALU from registers, captures Result/ALUFlags, and returns them tagged with the requester id.
- Only one operation is in flight at a time. The block sits between the instruction/issue logic and the ALU instance.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_rr_scheduler_if.sv | 27 ++
 rtl/alu_rr_scheduler_arb.sv | 35 +++
 rtl/alu_rr_scheduler.sv | 105 ++++++++++
 tb/tb_alu_rr_scheduler.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, flag bit positions and the scheduler FSM states.
package alu_pkg;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0001;
  localparam logic [3:0] OP_MUL  = 4'b0010;
  localparam logic [3:0] OP_DIV  = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0110;
  localparam logic [3:0] OP_UMUL = 4'b1111;

  localparam int unsigned FLAG_N = 3;
  localparam int unsigned FLAG_Z = 2;
  localparam int unsigned FLAG_C = 1;
  localparam int unsigned FLAG_V = 0;

  // Reported for a trapped divide: zero result, Z set.
  localparam logic [3:0] FLAGS_DIV0 = 4'b0100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_CAPT,
    S_RESP
  } state_t;

endpackage

// File: rtl/alu_rr_scheduler_if.sv
// Request/response bundle between the issue logic and the ALU scheduler.
interface alu_rr_scheduler_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*4-1:0]  req_op;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_result;
  logic [3:0]            rsp_flags;
  logic                  rsp_err;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_result, rsp_flags, rsp_err
  );
endinterface

// File: rtl/alu_rr_scheduler_arb.sv
// Combinational round-robin arbiter: first asserted request at or above ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 4,
  localparam int unsigned IW      = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      idx
);

  logic found;

  // Upper pass covers [ptr, NUM_REQ), lower pass supplies the wrap-around.
  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i] && (IW'(i) >= ptr)) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        found    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (!found && req[i]) begin
        grant[i] = 1'b1;
        idx      = IW'(i);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_rr_scheduler.sv
// Shares one combinational ALU between NUM_REQ requesters, one operation in flight,
// round-robin grant order; divide-by-zero can be answered without touching the ALU.
module alu_rr_scheduler
  import alu_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 4,
  parameter int unsigned ID_W      = 2,
  parameter bit          DIV0_TRAP = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  alu_rr_scheduler_if.slave        bus,
  output logic [31:0]              alu_a,
  output logic [31:0]              alu_b,
  output logic [3:0]               alu_ctrl,
  input  logic [31:0]              alu_result,
  input  logic [3:0]               alu_flags,
  output logic                     busy
);

  state_t                   state, state_n;
  logic [ID_W-1:0]          rr_ptr, gnt_idx, ptr_nxt;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0][31:0] req_a_arr, req_b_arr;
  logic [NUM_REQ-1:0][3:0]  req_op_arr;
  logic [31:0]              sel_a, sel_b;
  logic [3:0]               sel_op;
  logic                     req_fire, trap;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (gnt),
    .idx   (gnt_idx)
  );

  assign req_a_arr  = bus.req_a;
  assign req_b_arr  = bus.req_b;
  assign req_op_arr = bus.req_op;
  assign sel_a      = req_a_arr[gnt_idx];
  assign sel_b      = req_b_arr[gnt_idx];
  assign sel_op     = req_op_arr[gnt_idx];

  assign req_fire = (state == S_IDLE) && (|gnt);
  assign trap     = DIV0_TRAP && (sel_op == OP_DIV) && (sel_b == '0);
  assign ptr_nxt  = (gnt_idx == ID_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  // The grant is masked by rst_n so req_ready is zero for the whole reset window.
  always_comb begin
    state_n       = state;
    bus.req_ready = '0;
    bus.rsp_valid = 1'b0;
    busy          = 1'b1;
    unique case (state)
      S_IDLE: begin
        busy          = 1'b0;
        bus.req_ready = rst_n ? gnt : '0;
        if (req_fire) state_n = trap ? S_RESP : S_EXEC;
      end
      S_EXEC: state_n = S_CAPT;
      S_CAPT: state_n = S_RESP;
      S_RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr         <= '0;
      alu_a          <= '0;
      alu_b          <= '0;
      alu_ctrl       <= '0;
      bus.rsp_id     <= '0;
      bus.rsp_result <= '0;
      bus.rsp_flags  <= '0;
      bus.rsp_err    <= 1'b0;
    end else if (req_fire) begin
      rr_ptr     <= ptr_nxt;
      bus.rsp_id <= gnt_idx;
      // A trapped divide leaves the ALU operands untouched.
      if (trap) begin
        bus.rsp_result <= '0;
        bus.rsp_flags  <= FLAGS_DIV0;
        bus.rsp_err    <= 1'b1;
      end else begin
        alu_a    <= sel_a;
        alu_b    <= sel_b;
        alu_ctrl <= sel_op;
      end
    end else if (state == S_CAPT) begin
      bus.rsp_result <= alu_result;
      bus.rsp_flags  <= alu_flags;
      bus.rsp_err    <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_rr_scheduler.sv
// Bench for alu_rr_scheduler: directed scenarios plus random traffic against a
// transaction-level model (round-robin pick, per-op due cycle, expected response).
module tb_alu_rr_scheduler;
  import alu_pkg::*;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned ID_W    = 2;

  logic        clk;
  logic        rst_n;
  logic [31:0] alu_a, alu_b, alu_result;
  logic [3:0]  alu_ctrl, alu_flags;
  logic        busy;

  logic [NUM_REQ-1:0] rv;
  logic               rdy;
  logic [31:0]        ra [NUM_REQ];
  logic [31:0]        rb [NUM_REQ];
  logic [3:0]         rop[NUM_REQ];

  alu_rr_scheduler_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) bus();

  alu_rr_scheduler #(.NUM_REQ(NUM_REQ), .ID_W(ID_W), .DIV0_TRAP(1'b1)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_ctrl   (alu_ctrl),
    .alu_result (alu_result),
    .alu_flags  (alu_flags),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.req_valid = rv;
  assign bus.rsp_ready = rdy;
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_pack
    assign bus.req_a[32*gi +: 32] = ra[gi];
    assign bus.req_b[32*gi +: 32] = rb[gi];
    assign bus.req_op[4*gi +: 4]  = rop[gi];
  end

  // Stand-in ALU: {N,Z,C,V, result}
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op);
    logic [32:0] w;
    logic [63:0] p;
    logic [31:0] r;
    logic        c, v;
    w = '0; p = '0; c = 1'b0; v = 1'b0;
    case (op)
      OP_ADD:  begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32];
                     v = (a[31] == b[31]) && (r[31] != a[31]); end
      OP_SUB:  begin w = {1'b0, a} + {1'b0, ~b} + 33'd1; r = w[31:0]; c = w[32];
                     v = (a[31] != b[31]) && (r[31] != a[31]); end
      OP_MUL:  r = a * b;
      OP_DIV:  r = (b == 0) ? '1 : a / b;
      OP_NOT:  r = ~a;
      OP_UMUL: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
      default: r = a ^ b;
    endcase
    return {r[31], (r == 32'd0), c, v, r};
  endfunction

  assign {alu_flags, alu_result} = ref_alu(alu_a, alu_b, alu_ctrl);

  int              n_checks = 0;
  int              n_fail   = 0;
  int              cyc      = 0;
  int              ptr_m    = 0;
  bit              outst    = 0;
  int              due      = 0;
  logic [ID_W-1:0] exp_id;
  logic [31:0]     exp_res, last_a, last_b;
  logic [3:0]      exp_flags, last_op;
  bit              exp_err;
  bit              hold_valid = 0;
  bit              rnd_mode   = 0;
  bit              hs_flag;
  int              glog_id[$];
  int              glog_cyc[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NUM_REQ-1:0] rr_pick(input logic [NUM_REQ-1:0] v, input int p);
    logic [NUM_REQ-1:0] g;
    g = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (v[(p + k) % NUM_REQ]) begin
        g[(p + k) % NUM_REQ] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  function automatic int onehot_idx(input logic [NUM_REQ-1:0] v);
    for (int k = 0; k < NUM_REQ; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic model_reset();
    outst = 0; ptr_m = 0; last_a = '0; last_b = '0; last_op = '0;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_req_ready"}, bus.req_ready, 0);
    check({tag, "_alu_a"}, alu_a, 0);
    check({tag, "_alu_b"}, alu_b, 0);
    check({tag, "_alu_ctrl"}, alu_ctrl, 0);
    check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
    check({tag, "_rsp_id"}, bus.rsp_id, 0);
    check({tag, "_rsp_result"}, bus.rsp_result, 0);
    check({tag, "_rsp_flags"}, bus.rsp_flags, 0);
    check({tag, "_rsp_err"}, bus.rsp_err, 0);
    check({tag, "_busy"}, busy, 0);
  endtask

  task automatic drive_random();
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!rv[i] && $urandom_range(0, 2) == 0) begin
        ra[i]  = $urandom;
        rb[i]  = $urandom;
        rop[i] = 4'($urandom);
        case ($urandom_range(0, 3))
          0: begin rop[i] = OP_DIV; rb[i] = ($urandom_range(0, 1) == 1) ? 32'd0 : 32'($urandom_range(1, 9)); end
          1: rb[i] = ra[i];
          default: ;
        endcase
        rv[i] = 1'b1;
      end
    end
    rdy = ($urandom_range(0, 3) != 0);
  endtask

  task automatic check_outputs();
    bit resp_due;
    resp_due = outst && (cyc >= due);
    check("req_ready", bus.req_ready, outst ? '0 : rr_pick(rv, ptr_m));
    check("rsp_valid", bus.rsp_valid, resp_due);
    check("busy", busy, outst);
    check("alu_a", alu_a, last_a);
    check("alu_b", alu_b, last_b);
    check("alu_ctrl", alu_ctrl, last_op);
    if (resp_due) begin
      check("rsp_id", bus.rsp_id, exp_id);
      check("rsp_result", bus.rsp_result, exp_res);
      check("rsp_flags", bus.rsp_flags, exp_flags);
      check("rsp_err", bus.rsp_err, exp_err);
    end
  endtask

  // One clock: decide from the model what the coming edge consumes, then check after it.
  task automatic step();
    logic [NUM_REQ-1:0] pick;
    logic [35:0]        r;
    bit                 hs, rhs;
    int                 g;
    #1;
    if (bus.req_ready != 0) begin
      glog_id.push_back(onehot_idx(bus.req_ready));
      glog_cyc.push_back(cyc);
    end
    pick = outst ? '0 : rr_pick(rv, ptr_m);
    hs   = (pick != 0);
    g    = onehot_idx(pick);
    rhs  = outst && (cyc >= due) && rdy;
    @(posedge clk);
    #1;
    cyc++;
    hs_flag = hs;
    if (rhs) outst = 0;
    if (hs) begin
      ptr_m  = (g + 1) % NUM_REQ;
      outst  = 1;
      exp_id = ID_W'(g);
      if (rop[g] == OP_DIV && rb[g] == 0) begin
        due = cyc; exp_res = '0; exp_flags = 4'b0100; exp_err = 1'b1;
      end else begin
        r = ref_alu(ra[g], rb[g], rop[g]);
        due = cyc + 2; exp_res = r[31:0]; exp_flags = r[35:32]; exp_err = 1'b0;
        last_a = ra[g]; last_b = rb[g]; last_op = rop[g];
      end
      if (!hold_valid) rv[g] = 1'b0;
    end
    if (rnd_mode) drive_random();
    #1;
    check_outputs();
  endtask

  task automatic issue(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    int k;
    ra[i] = a; rb[i] = b; rop[i] = op; rv[i] = 1'b1;
    k = 0;
    hs_flag = 0;
    while (!hs_flag && k < 20) begin step(); k++; end
    if (!hs_flag) check("grant_timeout", 0, 1);
  endtask

  // Latency counted in cycles from the handshake cycle to the first rsp_valid cycle.
  task automatic wait_rsp(output int lat);
    int n;
    n = 0;
    while (bus.rsp_valid !== 1'b1 && n < 20) begin step(); n++; end
    if (bus.rsp_valid !== 1'b1) check("rsp_timeout", 0, 1);
    lat = n + 1;
  endtask

  task automatic run_op(input int i, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] op, output int lat);
    issue(i, a, b, op);
    wait_rsp(lat);
  endtask

  task automatic drain();
    int k;
    hold_valid = 0; rdy = 1'b1; k = 0;
    while ((outst || rv != 0) && k < 100) begin step(); k++; end
    if (outst || rv != 0) check("drain_timeout", 0, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    rst_n = 1'b0; rv = '0; rdy = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin ra[i] = '0; rb[i] = '0; rop[i] = '0; end
    model_reset();
    repeat (3) @(posedge clk);
    rv = 4'b1111;
    #2;
    check_reset("reset");
    rv = '0;
    @(posedge clk); #2;
    rst_n = 1'b1;

    // Fairness: all requesters held valid
    for (int i = 0; i < NUM_REQ; i++) begin ra[i] = 32'(i * 10 + 1); rb[i] = 32'(i); rop[i] = OP_ADD; end
    glog_id.delete(); glog_cyc.delete();
    rv = 4'b1111; hold_valid = 1; rdy = 1'b1;
    repeat (20) step();
    drain();
    for (int k = 0; k < 5; k++) begin
      if (k < glog_id.size()) begin
        check($sformatf("fair_id%0d", k), glog_id[k], k % NUM_REQ);
        if (k > 0) check($sformatf("fair_gap%0d", k), glog_cyc[k] - glog_cyc[k-1], 4);
      end else check("fair_missing", 0, 1);
    end

    // Single op
    run_op(0, 32'd5, 32'd7, OP_ADD, lat);
    check("single_lat", lat, 3);
    check("single_id", bus.rsp_id, 0);
    check("single_result", bus.rsp_result, 12);
    check("single_flags", bus.rsp_flags, 4'b0000);
    check("single_err", bus.rsp_err, 0);

    // Flag passthrough
    run_op(1, 32'd3, 32'd3, OP_SUB, lat);
    check("sub_result", bus.rsp_result, 0);
    check("sub_flag_z", bus.rsp_flags[FLAG_Z], 1);
    run_op(1, 32'd0, 32'h55, OP_NOT, lat);
    check("not_result", bus.rsp_result, 32'hFFFF_FFFF);
    check("not_flag_n", bus.rsp_flags[FLAG_N], 1);

    // Trapped divide
    run_op(2, 32'd100, 32'd0, OP_DIV, lat);
    check("div0_lat", lat, 1);
    check("div0_id", bus.rsp_id, 2);
    check("div0_result", bus.rsp_result, 0);
    check("div0_flags", bus.rsp_flags, 4'b0100);
    check("div0_err", bus.rsp_err, 1);
    check("div0_alu_a", alu_a, 0);
    check("div0_alu_b", alu_b, 32'h55);
    check("div0_alu_ctrl", alu_ctrl, OP_NOT);

    // Backpressure
    drain();
    rdy = 1'b0;
    run_op(1, 32'd20, 32'd22, OP_ADD, lat);
    check("bp_lat", lat, 3);
    ra[3] = 32'd9; rb[3] = 32'd1; rop[3] = OP_SUB; rv[3] = 1'b1;
    repeat (10) begin
      step();
      check("bp_valid", bus.rsp_valid, 1);
      check("bp_id", bus.rsp_id, 1);
      check("bp_result", bus.rsp_result, 42);
      check("bp_req_ready", bus.req_ready, 0);
    end
    rdy = 1'b1;
    step();
    check("bp_next_grant", bus.req_ready, 4'b1000);
    drain();

    // Reset during EXEC
    issue(2, 32'd7, 32'd8, OP_ADD);
    rst_n = 1'b0;
    rv = 4'b1010;
    ra[1] = 32'd1; rb[1] = 32'd2; rop[1] = OP_ADD;
    ra[3] = 32'd3; rb[3] = 32'd4; rop[3] = OP_ADD;
    model_reset();
    #1;
    check_reset("midrst");
    repeat (2) @(posedge clk);
    #2;
    check_reset("midrst_hold");
    rst_n = 1'b1;
    #1;
    check("rst_first_grant", bus.req_ready, 4'b0010);
    drain();

    // Random traffic
    rnd_mode = 1;
    repeat (3000) step();
    rnd_mode = 0;
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
